// File: rtl/syscall_print_ctrl_pkg.sv
// syscall_print_ctrl_pkg: shared state type, data-memory window and syscall code
package syscall_print_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;
  localparam logic [31:0] DMEM_LO_ADDR = 32'h7FFF_FBFC;
  localparam logic [31:0] DMEM_HI_ADDR = 32'h7FFF_FFFC;
  localparam logic [31:0] SYSCALL_PRINT_STRING = 32'd4;
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [31:0] s;
    s = word >> {lane, 3'b000};
    return s[7:0];
  endfunction
endpackage

// File: rtl/syscall_print_ctrl_if.sv
// syscall_print_ctrl_if: CPU, data-memory, syscall and console signals of the print controller
interface syscall_print_ctrl_if;
  logic        cpu_memRead;
  logic        cpu_memWrite;
  logic [31:0] cpu_address;
  logic [31:0] cpu_writeData;
  logic [31:0] cpu_readData;
  logic        sys_start;
  logic [31:0] sys_addr;
  logic        stall;
  logic        mem_memRead;
  logic        mem_memWrite;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic [31:0] mem_readData;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        done;
  logic        err;
  modport slave (
    input  cpu_memRead, cpu_memWrite, cpu_address, cpu_writeData, sys_start, sys_addr,
           mem_readData, char_ready,
    output cpu_readData, stall, mem_memRead, mem_memWrite, mem_address, mem_writeData,
           char_valid, char_data, done, err
  );
  modport master (
    output cpu_memRead, cpu_memWrite, cpu_address, cpu_writeData, sys_start, sys_addr,
           mem_readData, char_ready,
    input  cpu_readData, stall, mem_memRead, mem_memWrite, mem_address, mem_writeData,
           char_valid, char_data, done, err
  );
endinterface

// File: rtl/syscall_print_ctrl_dmem_port_mux.sv
// dmem_port_mux: hands the data-memory port to the CPU or to the string walker
module dmem_port_mux (
  input  logic        i_owner,
  input  logic        i_cpu_memRead,
  input  logic        i_cpu_memWrite,
  input  logic [31:0] i_cpu_address,
  input  logic [31:0] i_cpu_writeData,
  output logic [31:0] o_cpu_readData,
  input  logic        i_ctl_memRead,
  input  logic [31:0] i_ctl_address,
  output logic        o_mem_memRead,
  output logic        o_mem_memWrite,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_writeData,
  input  logic [31:0] i_mem_readData
);
  assign o_mem_memRead   = i_owner ? i_ctl_memRead : i_cpu_memRead;
  assign o_mem_memWrite  = i_owner ? 1'b0 : i_cpu_memWrite;
  assign o_mem_address   = i_owner ? i_ctl_address : i_cpu_address;
  assign o_mem_writeData = i_owner ? 32'd0 : i_cpu_writeData;
  assign o_cpu_readData  = i_owner ? 32'd0 : i_mem_readData;
endmodule

// File: rtl/syscall_print_ctrl.sv
// syscall_print_ctrl: print_string syscall sequencer and data-memory port arbiter
// DMEM_RANGE_CHECK_EN: refuse fetches outside the implemented data-memory window
module syscall_print_ctrl
  import syscall_print_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 256
) (
  input logic                 clk,
  input logic                 rst_n,
  syscall_print_ctrl_if.slave bus
);
  state_t      r_state;
  logic [31:0] r_ptr;
  logic [31:0] r_count;
  logic [31:0] r_word;
  logic        r_err;
  logic [31:0] w_fetch_addr;
  logic [31:0] w_ptr_nxt;
  logic [31:0] w_count_nxt;
  logic [7:0]  w_byte;
  logic        w_owner;
  logic        w_emit;
  logic        w_in_range;
  assign w_fetch_addr = {r_ptr[31:2], 2'b00};
  assign w_ptr_nxt    = r_ptr + 32'd1;
  assign w_count_nxt  = r_count + 32'd1;
  assign w_byte       = pick_byte(r_word, r_ptr[1:0]);
  assign w_owner      = r_state != IDLE;
  assign w_emit       = rst_n && r_state == EMIT && w_byte != 8'd0;
`ifdef DMEM_RANGE_CHECK_EN
  assign w_in_range = w_fetch_addr >= DMEM_LO_ADDR && w_fetch_addr <= DMEM_HI_ADDR;
`else
  assign w_in_range = 1'b1;
`endif
  // stall covers the sys_start cycle itself so the syscall cannot retire early
  assign bus.stall      = rst_n && (w_owner || bus.sys_start);
  assign bus.done       = rst_n && r_state == DONE;
  assign bus.char_valid = w_emit;
  assign bus.char_data  = w_emit ? w_byte : 8'd0;
  assign bus.err        = r_err;
  dmem_port_mux u_mux (
    .i_owner        (w_owner),
    .i_cpu_memRead  (bus.cpu_memRead),
    .i_cpu_memWrite (bus.cpu_memWrite),
    .i_cpu_address  (bus.cpu_address),
    .i_cpu_writeData(bus.cpu_writeData),
    .o_cpu_readData (bus.cpu_readData),
    .i_ctl_memRead  (r_state == FETCH && w_in_range),
    .i_ctl_address  (w_fetch_addr),
    .o_mem_memRead  (bus.mem_memRead),
    .o_mem_memWrite (bus.mem_memWrite),
    .o_mem_address  (bus.mem_address),
    .o_mem_writeData(bus.mem_writeData),
    .i_mem_readData (bus.mem_readData)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 32'd0;
      r_count <= 32'd0;
      r_word  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.sys_start) begin
          r_ptr   <= bus.sys_addr;
          r_count <= 32'd0;
          r_err   <= 1'b0;
          r_state <= FETCH;
        end
        FETCH: if (w_in_range) begin
          r_word  <= bus.mem_readData;
          r_state <= EMIT;
        end else begin
          r_err   <= 1'b1;
          r_state <= DONE;
        end
        EMIT: if (w_byte == 8'd0) r_state <= DONE;
        else if (bus.char_ready) begin
          r_ptr   <= w_ptr_nxt;
          r_count <= w_count_nxt;
          // refetch only when the pointer crosses into the next word
          if (w_count_nxt == 32'(MAX_LEN)) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end else if (w_ptr_nxt[1:0] == 2'b00) r_state <= FETCH;
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end
endmodule
